// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - clip indices, clip address table and scheduler state encoding
package sound_pkg;

    localparam int SND_WIN    = 0;
    localparam int SND_DETECT = 1;
    localparam int SND_MOO    = 2;
    localparam int SND_CHEER  = 3;

    localparam int CLIP_ADDR_W = 18;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FETCH,
        ST_CAPTURE,
        ST_WAIT
    } state_t;

    function automatic logic [CLIP_ADDR_W-1:0] clip_start(input logic [1:0] id);
        case (id)
            2'(SND_WIN):    clip_start = 18'd0;
            2'(SND_DETECT): clip_start = 18'd66983;
            2'(SND_MOO):    clip_start = 18'd16396;
            default:        clip_start = 18'd83255;
        endcase
    endfunction

    function automatic logic [CLIP_ADDR_W-1:0] clip_end(input logic [1:0] id);
        case (id)
            2'(SND_WIN):    clip_end = 18'd16395;
            2'(SND_DETECT): clip_end = 18'd83254;
            2'(SND_MOO):    clip_end = 18'd66982;
            default:        clip_end = 18'd137138;
        endcase
    endfunction

endpackage

// File: rtl/sound_req_arbiter.sv
// rtl/sound_req_arbiter.sv - latched sound requests with fixed lowest-index-wins priority
module sound_req_arbiter #(
    parameter int NUM_SRC = 4
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               audio_en,
    input  logic [NUM_SRC-1:0] req,
    input  logic               busy,
    input  logic [1:0]         active_id,
    input  logic               clr,
    input  logic [1:0]         clr_id,
    output logic [1:0]         winner,
    output logic               any_pending
);

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] set_mask;
    logic [NUM_SRC-1:0] clr_mask;

    // A request for the clip already playing must not queue a restart.
    always_comb begin
        set_mask = req;
        if (busy) set_mask[active_id] = 1'b0;
        clr_mask = '0;
        if (clr) clr_mask[clr_id] = 1'b1;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            pending <= '0;
        else if (!audio_en)
            pending <= '0;
        else
            pending <= (pending & ~clr_mask) | set_mask;
    end

    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (pending[i]) winner = 2'(i);
    end

    assign any_pending = |pending;

endmodule

// File: rtl/sound_scheduler.sv
// rtl/sound_scheduler.sv - paced playback of prioritized sound clips from a shared ROM
module sound_scheduler
    import sound_pkg::*;
#(
    parameter int ADDR_W   = 18,
    parameter int SAMPLE_W = 6,
    parameter int DIV      = 1200,
    parameter int NUM_SRC  = 4
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                audio_en,
    input  logic [NUM_SRC-1:0]  req,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [SAMPLE_W-1:0] rom_q,
    input  logic                audio_out_allowed,
    output logic [31:0]         left_channel_audio_out,
    output logic [31:0]         right_channel_audio_out,
    output logic                write_audio_out,
    output logic                busy,
    output logic [1:0]          active_id,
    output logic                clip_done
);

    localparam int PACE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PACE_W-1:0] PACE_TOP = PACE_W'(DIV - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   end_addr;
    logic [SAMPLE_W-1:0] sample_reg;
    logic [PACE_W-1:0]   pace_cnt;
    logic [1:0]          winner;
    logic                any_pending;
    logic                load;
    logic                do_write;
    logic                last_sample;

    sound_req_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .audio_en    (audio_en),
        .req         (req),
        .busy        (busy),
        .active_id   (active_id),
        .clr         (load),
        .clr_id      (winner),
        .winner      (winner),
        .any_pending (any_pending)
    );

    assign load        = (state_q == ST_LOAD) && audio_en;
    assign last_sample = (rom_addr == end_addr);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Preemption is checked before the write so a held sample is dropped, never emitted.
    always_comb begin
        state_d  = state_q;
        do_write = 1'b0;
        case (state_q)
            ST_IDLE:    if (any_pending) state_d = ST_LOAD;
            ST_LOAD:    state_d = ST_FETCH;
            ST_FETCH:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (any_pending && (winner < active_id)) begin
                    state_d = ST_LOAD;
                end else if ((pace_cnt == PACE_TOP) && audio_out_allowed) begin
                    do_write = 1'b1;
                    state_d  = last_sample ? ST_IDLE : ST_FETCH;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
        if (!audio_en) begin
            state_d  = ST_IDLE;
            do_write = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rom_addr               <= '0;
            end_addr               <= '0;
            active_id              <= '0;
            busy                   <= 1'b0;
            sample_reg             <= '0;
            pace_cnt               <= '0;
            left_channel_audio_out <= '0;
            write_audio_out        <= 1'b0;
            clip_done              <= 1'b0;
        end else begin
            write_audio_out <= do_write;
            clip_done       <= do_write && last_sample;
            if (!audio_en) begin
                busy <= 1'b0;
            end else if (load) begin
                active_id <= winner;
                rom_addr  <= ADDR_W'(clip_start(winner));
                end_addr  <= ADDR_W'(clip_end(winner));
                busy      <= 1'b1;
                pace_cnt  <= '0;
            end else begin
                if (state_q == ST_CAPTURE) sample_reg <= rom_q;
                if (do_write) begin
                    left_channel_audio_out <= {sample_reg, {(32 - SAMPLE_W){1'b0}}};
                    pace_cnt               <= '0;
                    if (last_sample) busy <= 1'b0;
                    else             rom_addr <= rom_addr + 1'b1;
                end else if (busy && (pace_cnt != PACE_TOP)) begin
                    pace_cnt <= pace_cnt + 1'b1;
                end
            end
        end
    end

    assign right_channel_audio_out = 32'd0;

endmodule

// File: tb/tb_sound_scheduler.sv
// tb/tb_sound_scheduler.sv - randomized self-checking bench for sound_scheduler
module tb_sound_scheduler;

    localparam int DIV = 4;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        audio_en = 1'b0;
    logic [3:0]  req = 4'b0;
    logic [17:0] rom_addr;
    logic [5:0]  rom_q = 6'd0;
    logic        audio_out_allowed = 1'b1;
    logic [31:0] left_channel_audio_out;
    logic [31:0] right_channel_audio_out;
    logic        write_audio_out;
    logic        busy;
    logic [1:0]  active_id;
    logic        clip_done;

    int checks = 0;
    int failures = 0;
    int unsigned seed = 0;

    logic [31:0] wr_left[$];
    int          wr_cyc[$];
    int          done_cyc[$];
    int          fall_cyc[$];
    int          cyc = 0;
    logic        busy_prev = 1'b0;

    always #5 CLOCK_50 = ~CLOCK_50;

    sound_scheduler #(.ADDR_W(18), .SAMPLE_W(6), .DIV(DIV), .NUM_SRC(4)) dut (
        .CLOCK_50                (CLOCK_50),
        .reset                   (reset),
        .audio_en                (audio_en),
        .req                     (req),
        .rom_addr                (rom_addr),
        .rom_q                   (rom_q),
        .audio_out_allowed       (audio_out_allowed),
        .left_channel_audio_out  (left_channel_audio_out),
        .right_channel_audio_out (right_channel_audio_out),
        .write_audio_out         (write_audio_out),
        .busy                    (busy),
        .active_id               (active_id),
        .clip_done               (clip_done)
    );

    function automatic logic [5:0] rom_f(input int a);
        logic [31:0] h;
        h = (a * 32'h9E3779B1) ^ seed;
        h = h ^ (h >> 13);
        return h[11:6];
    endfunction

    function automatic logic [31:0] exp_left(input int a);
        return {rom_f(a), 26'b0};
    endfunction

    always @(posedge CLOCK_50) rom_q <= rom_f(int'(rom_addr));

    always @(posedge CLOCK_50) begin
        #1;
        cyc++;
        if (write_audio_out) begin
            wr_left.push_back(left_channel_audio_out);
            wr_cyc.push_back(cyc);
        end
        if (clip_done) done_cyc.push_back(cyc);
        if (busy_prev && !busy) fall_cyc.push_back(cyc);
        busy_prev = busy;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mism(input int first, input int n, input int addr0);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (first + i >= wr_left.size()) bad++;
            else if (wr_left[first + i] !== exp_left(addr0 + i)) bad++;
        end
        return bad;
    endfunction

    task automatic pulse(input logic [3:0] m);
        req = m;
        @(negedge CLOCK_50);
        req = 4'b0;
    endtask

    initial begin
        int n, bad, c_cheer, c_moo0, c_det, n0, c0, last_wr;
        seed = $urandom;

        repeat (3) @(negedge CLOCK_50);
        check("reset_ctrl", {write_audio_out, busy, clip_done, active_id, rom_addr}, 64'd0);
        check("reset_left", left_channel_audio_out, 32'd0);
        check("reset_right", right_channel_audio_out, 32'd0);
        check("reset_pending", dut.u_arb.pending, 4'd0);

        reset = 1'b0;
        audio_en = 1'b1;
        @(negedge CLOCK_50);

        // cheer starts, then win and moo arrive together
        pulse(4'b1000);
        n = 0;
        while (!(busy && active_id == 2'd3) && n < 20) begin @(negedge CLOCK_50); n++; end
        check("cheer_start_timeout", n < 20, 1'b1);
        check("cheer_start_addr", rom_addr, 18'd83255);
        n = 0;
        while (wr_left.size() < 2 && n < 40) begin @(negedge CLOCK_50); n++; end
        check("cheer_writes_timeout", n < 40, 1'b1);
        pulse(4'b0101);
        n = 0;
        while (active_id != 2'd0 && n < 20) begin @(negedge CLOCK_50); n++; end
        check("preempt_cheer_timeout", n < 20, 1'b1);
        c_cheer = wr_left.size();
        check("cheer_write_count", c_cheer, 2);
        check("cheer_data", mism(0, 2, 83255), 0);
        check("win_start_addr", rom_addr, 18'd0);
        check("cheer_no_done", done_cyc.size(), 0);

        n = 0;
        while (done_cyc.size() == 0 && n < 70000) begin @(negedge CLOCK_50); n++; end
        check("win_done_timeout", n < 70000, 1'b1);
        check("win_write_count", wr_left.size() - c_cheer, 16396);
        check("win_data", mism(c_cheer, 16396, 0), 0);
        bad = 0;
        for (int i = c_cheer + 1; i < wr_cyc.size(); i++)
            if (wr_cyc[i] - wr_cyc[i-1] != DIV) bad++;
        check("win_spacing", bad, 0);
        last_wr = (wr_cyc.size() > c_cheer) ? wr_cyc[wr_cyc.size()-1] : -1;
        check("win_done_edge", (done_cyc.size() > 0) ? done_cyc[0] : -2, last_wr);
        check("win_busy_fall_edge", (fall_cyc.size() > 0) ? fall_cyc[0] : -2, last_wr);

        repeat (5) @(negedge CLOCK_50);
        check("done_once", done_cyc.size(), 1);
        check("moo_start_id", active_id, 2'd2);
        check("moo_start_addr", rom_addr, 18'd16396);
        check("moo_busy", busy, 1'b1);
        check("pending_empty", dut.u_arb.pending, 4'd0);

        // moo with random backpressure, then a 50-cycle hold
        c_moo0 = wr_left.size();
        n = 0;
        while (wr_left.size() - c_moo0 < 4 && n < 400) begin
            audio_out_allowed = 1'($urandom_range(0, 1));
            @(negedge CLOCK_50);
            n++;
        end
        check("moo_random_timeout", n < 400, 1'b1);
        audio_out_allowed = 1'b0;
        c0 = cyc;
        n0 = wr_left.size();
        repeat (50) @(negedge CLOCK_50);
        check("bp_no_writes", wr_left.size(), n0);
        check("bp_left_held", left_channel_audio_out, exp_left(16396 + n0 - c_moo0 - 1));
        audio_out_allowed = 1'b1;
        @(negedge CLOCK_50);
        check("bp_first_write_count", wr_left.size(), n0 + 1);
        check("bp_first_write_edge", (wr_cyc.size() > 0) ? wr_cyc[wr_cyc.size()-1] : -1, c0 + 51);

        n = 0;
        while (wr_left.size() - c_moo0 < 10 && n < 100) begin @(negedge CLOCK_50); n++; end
        check("moo_ten_timeout", n < 100, 1'b1);
        repeat (2) @(negedge CLOCK_50);
        pulse(4'b0010);
        repeat (2) @(negedge CLOCK_50);
        check("preempt_addr", rom_addr, 18'd66983);
        check("preempt_id", active_id, 2'd1);
        check("preempt_no_write", wr_left.size() - c_moo0, 10);
        check("moo_data", mism(c_moo0, 10, 16396), 0);
        check("preempt_no_done", done_cyc.size(), 1);

        // audio_en dropped during detect
        c_det = wr_left.size();
        n = 0;
        while (wr_left.size() - c_det < 2 && n < 40) begin @(negedge CLOCK_50); n++; end
        check("detect_timeout", n < 40, 1'b1);
        pulse(4'b1000);
        check("cheer_queued", dut.u_arb.pending, 4'b1000);
        audio_en = 1'b0;
        n0 = wr_left.size();
        @(negedge CLOCK_50);
        check("abort_busy", busy, 1'b0);
        check("abort_addr_held", rom_addr, 18'd66985);
        check("abort_pending", dut.u_arb.pending, 4'd0);
        pulse(4'b0001);
        pulse(4'b0100);
        repeat (5) @(negedge CLOCK_50);
        check("disabled_pending", dut.u_arb.pending, 4'd0);
        check("disabled_no_write", wr_left.size(), n0);
        audio_en = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        check("reenable_idle", busy, 1'b0);
        check("abort_no_done", done_cyc.size(), 1);
        check("detect_data", mism(c_det, 2, 66983), 0);

        // asynchronous reset while a write strobe is high
        pulse(4'b0001);
        n = 0;
        while (!write_audio_out && n < 40) begin @(negedge CLOCK_50); n++; end
        check("reset_write_timeout", n < 40, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_ctrl", {write_audio_out, busy, clip_done, active_id, rom_addr}, 64'd0);
        check("async_left", left_channel_audio_out, 32'd0);
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        n0 = wr_left.size();
        repeat (20) @(negedge CLOCK_50);
        check("post_reset_no_write", wr_left.size(), n0);
        check("post_reset_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
